// File: rtl/cmac_tx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cmac_tx_pkt_buffer
// Purpose  : Store-and-forward packet buffer between the ERNIC TX AXI-Stream
//            source and the CMAC TX AXIS port (txusrclk2 domain). A packet is
//            released to the CMAC only after its last beat has been stored.
//            The CMAC therefore never sees a mid-packet bubble. Oversized,
//            errored and queue-overflowing packets are discarded on the input
//            side, and each discard is reported on the status outputs.
//
// Ports    : aclk, aresetn        clock / asynchronous active-low reset
//            s_axis_*             input stream (tuser = error, valid on tlast)
//            m_axis_*             output stream to CMAC (tuser tied to 0)
//            pkt_count            committed packets not yet fully sent
//            drop_count           saturating count of dropped packets
//            drop_pulse           one-cycle pulse per dropped packet
//
// Revision : 1.0 - initial release
// ============================================================================
module cmac_tx_pkt_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int DEPTH      = 64,
  parameter int MAX_PKTS   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  // input stream
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]       s_axis_tkeep,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tuser,
  output logic                        s_axis_tready,
  // output stream
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  // status
  output logic [$clog2(MAX_PKTS):0]   pkt_count,
  output logic [31:0]                 drop_count,
  output logic                        drop_pulse
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_pcnt_w = $clog2(MAX_PKTS) + 1;
  // RAM word layout: {tlast, tkeep, tdata}
  localparam int c_word_w = DATA_WIDTH + KEEP_WIDTH + 1;

  localparam logic [c_addr_w:0]   c_depth    = (c_addr_w + 1)'(DEPTH);
  localparam logic [c_pcnt_w-1:0] c_max_pkts = c_pcnt_w'(MAX_PKTS);

  // --------------------------------------------------------------------------
  // Write-side packet state
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,   // waiting for the first beat of a packet
    S_STORE = 2'd1,   // storing the body of an accepted packet
    S_DROP  = 2'd2    // discarding the rest of a packet through its tlast
  } wr_state_e;

  wr_state_e                r_wr_state;
  wr_state_e                w_wr_state_nxt;

  logic                     r_s_tready;
  // Pointers are one bit wider than the RAM address so full/empty differ.
  logic [c_addr_w:0]        r_wr_ptr;
  logic [c_addr_w:0]        r_pkt_start;
  logic [c_addr_w:0]        r_wr_commit;
  logic [c_addr_w:0]        r_rd_ptr;

  logic [c_pcnt_w-1:0]      r_pkt_count;
  logic [31:0]              r_drop_count;
  logic                     r_drop_pulse;

  logic                     w_s_acc;
  logic [c_addr_w:0]        w_used;
  logic                     w_ram_full;
  logic                     w_q_full;
  logic                     w_drop_cond;
  logic                     w_wr_en;
  logic                     w_commit;
  logic                     w_drop_end;
  logic [c_addr_w:0]        w_pkt_start;

  // --------------------------------------------------------------------------
  // Read-side pipeline
  // --------------------------------------------------------------------------
  logic [c_word_w-1:0]      r_mem [DEPTH];
  logic [c_word_w-1:0]      r_rdata;
  logic                     r_rd_vld;
  logic [c_word_w-1:0]      r_skid [2];
  logic                     r_head;
  logic                     r_tail;
  logic [1:0]               r_skid_cnt;

  logic                     w_rd_avail;
  logic                     w_rd_en;
  logic                     w_pop;
  logic                     w_out_last;
  logic [1:0]               w_skid_cnt_nxt;
  logic [c_word_w-1:0]      w_head;

  assign w_s_acc    = s_axis_tvalid & r_s_tready;
  assign w_used     = r_wr_ptr - r_rd_ptr;
  assign w_ram_full = (w_used == c_depth);
  assign w_q_full   = (r_pkt_count == c_max_pkts);

  // Next-state and write controls. Any accepted beat that is not written
  // belongs to a dropped packet.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_drop_cond    = 1'b1;
    w_wr_en        = 1'b0;
    w_commit       = 1'b0;
    w_drop_end     = 1'b0;
    w_pkt_start    = r_pkt_start;

    case (r_wr_state)
      S_IDLE: begin
        // The packet starts at the current write pointer. The queue-full
        // check applies only to the first beat.
        w_pkt_start = r_wr_ptr;
        w_drop_cond = w_ram_full | w_q_full | (s_axis_tlast & s_axis_tuser);
      end
      S_STORE: begin
        w_drop_cond = w_ram_full | (s_axis_tlast & s_axis_tuser);
      end
      S_DROP: begin
        w_drop_cond = 1'b1;
      end
      default: begin
        w_drop_cond = 1'b1;
      end
    endcase

    if (w_s_acc) begin
      w_wr_en    = ~w_drop_cond;
      w_commit   = ~w_drop_cond & s_axis_tlast;
      w_drop_end =  w_drop_cond & s_axis_tlast;
      if (s_axis_tlast) begin
        w_wr_state_nxt = S_IDLE;
      end else if (w_drop_cond) begin
        w_wr_state_nxt = S_DROP;
      end else begin
        w_wr_state_nxt = S_STORE;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_state <= S_IDLE;
    end else begin
      r_wr_state <= w_wr_state_nxt;
    end
  end

  // Write pointers. On a drop the pointer rewinds to the packet start. The
  // rewind repeats on every discarded beat and leaves the pointer unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_s_tready  <= 1'b0;
      r_wr_ptr    <= '0;
      r_pkt_start <= '0;
      r_wr_commit <= '0;
    end else begin
      r_s_tready <= 1'b1;
      if (w_s_acc && (r_wr_state == S_IDLE)) begin
        r_pkt_start <= r_wr_ptr;
      end
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end else if (w_s_acc) begin
        r_wr_ptr <= w_pkt_start;
      end
      if (w_commit) begin
        r_wr_commit <= r_wr_ptr + 1'b1;
      end
    end
  end

  // Drop reporting: the pulse and the counter update together on the edge
  // that accepts the dropped packet's tlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_pulse <= w_drop_end;
      if (w_drop_end && (r_drop_count != 32'hFFFF_FFFF)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  // Packet count: up on commit, down on the output tlast transfer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_commit, w_out_last})
        2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
        2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Data RAM: synchronous write, registered read (1-cycle latency).
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_addr_w-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
    if (w_rd_en) begin
      r_rdata <= r_mem[r_rd_ptr[c_addr_w-1:0]];
    end
  end

  // Reading may advance only through committed beats. A read is issued when
  // the skid has room for it on arrival, after counting the beat already in
  // the RAM output register and this cycle's pop. A 2-entry skid allows one
  // beat per cycle with no gaps.
  assign w_pop          = m_axis_tvalid & m_axis_tready;
  assign w_out_last     = w_pop & m_axis_tlast;
  assign w_skid_cnt_nxt = r_skid_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
  assign w_rd_avail     = (r_rd_ptr != r_wr_commit);
  assign w_rd_en        = w_rd_avail & (w_skid_cnt_nxt <= 2'd1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_ptr <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Output skid: entries are written only at the tail. The head stays
  // stable while the CMAC stalls.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (r_rd_vld) begin
        r_skid[r_tail] <= r_rdata;
        r_tail         <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      r_skid_cnt <= w_skid_cnt_nxt;
    end
  end

  assign w_head        = r_skid[r_head];
  assign m_axis_tdata  = w_head[DATA_WIDTH-1:0];
  assign m_axis_tkeep  = w_head[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast  = w_head[c_word_w-1];
  assign m_axis_tvalid = (r_skid_cnt != 2'd0);
  assign m_axis_tuser  = 1'b0;

  assign s_axis_tready = r_s_tready;
  assign pkt_count     = r_pkt_count;
  assign drop_count    = r_drop_count;
  assign drop_pulse    = r_drop_pulse;

endmodule
`default_nettype wire

// File: tb/tb_cmac_tx_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmac_tx_pkt_buffer
// Purpose  : Directed scoreboard bench for cmac_tx_pkt_buffer. The stimulus
//            pushes the beats that must appear on the output. A negedge
//            monitor pops and compares them, and it also checks hold-while-
//            stalled and the absence of gaps inside a packet.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmac_tx_pkt_buffer;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int DEPTH = 64;
  localparam int MAXP  = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tuser;
  logic          m_tready = 1'b1;
  logic [4:0]    pkt_count;
  logic [31:0]   drop_count;
  logic          drop_pulse;

  int    total = 0;
  int    bad = 0;
  int    beats_out = 0;
  int    drops_seen = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  cmac_tx_pkt_buffer #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .DEPTH      (DEPTH),
    .MAX_PKTS   (MAXP)
  ) u_dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .drop_pulse    (drop_pulse)
  );

  function automatic logic [DW-1:0] mkdata(input int pid, input int beat);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) begin
      d[i*32 +: 32] = {pid[7:0], beat[7:0], i[7:0], 8'hA5};
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one packet one beat per cycle. The call must start 1ns after a
  // posedge, and it returns 1ns after the edge that accepts tlast.
  task automatic send_pkt(input int pid, input int n, input logic [KW-1:0] lkeep,
                          input logic err, input bit expect_out);
    beat_t b;
    chk($sformatf("s_tready_pkt%0d", pid), 64'(s_tready), 64'd1);
    for (int i = 0; i < n; i++) begin
      s_tdata  = mkdata(pid, i);
      s_tkeep  = (i == n - 1) ? lkeep : '1;
      s_tlast  = (i == n - 1);
      s_tuser  = (i == n - 1) ? err : 1'b0;
      s_tvalid = 1'b1;
      if (expect_out) begin
        b.d = s_tdata; b.k = s_tkeep; b.l = s_tlast;
        exp_q.push_back(b);
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
      tick(1);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d, required 0", nm, exp_q.size());
    end
  endtask

  // Scoreboard monitor
  logic  mid = 1'b0;
  logic  pv = 1'b0;
  logic  pr = 1'b0;
  beat_t pb;

  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur.d = m_tdata; cur.k = m_tkeep; cur.l = m_tlast;
    if (!aresetn) begin
      mid = 1'b0;
      pv  = 1'b0;
      pr  = 1'b0;
    end else begin
      if (pv && !pr) begin
        total++;
        if (!m_tvalid || cur !== pb) begin
          bad++;
          $display("FAIL hold: valid=%0b last=%0b keep=%h, required valid=1 last=%0b keep=%h",
                   m_tvalid, cur.l, cur.k, pb.l, pb.k);
        end
      end
      if (mid) begin
        total++;
        if (!m_tvalid) begin
          bad++;
          $display("FAIL gap: m_tvalid=0 inside packet, required 1");
        end
      end
      if (m_tvalid && m_tready) begin
        beats_out++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected beat data=%h, required none", m_tdata[63:0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e || m_tuser !== 1'b0) begin
            bad++;
            $display("FAIL beat: data=%h keep=%h last=%0b user=%0b, required data=%h keep=%h last=%0b user=0",
                     cur.d, cur.k, cur.l, m_tuser, e.d, e.k, e.l);
          end
        end
        mid = !m_tlast;
      end
      pv = m_tvalid;
      pr = m_tready;
      pb = cur;
      if (drop_pulse) drops_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int b0;
    int d0;
    int n;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_m_tdata", m_tdata[63:0], 64'd0);
    chk("rst_m_tkeep", m_tkeep, 64'd0);
    aresetn = 1'b1;
    #1;
    chk("s_tready_before_edge", 64'(s_tready), 64'd0);
    tick(1);
    chk("s_tready_after_edge", 64'(s_tready), 64'd1);

    // ---------------- T1: 9-beat packet, latency ----------------
    b0 = beats_out;
    chk("t1_pkt_count_start", 64'(pkt_count), 64'd0);
    send_pkt(1, 9, 64'h3FF, 1'b0, 1'b1);
    lat = 0;
    @(negedge clk);
    chk("t1_pkt_count_commit", 64'(pkt_count), 64'd1);
    while (!m_tvalid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("t1_first_beat_latency", 64'(lat), 64'd2);
    tick(1);
    wait_drain("t1");
    chk("t1_pkt_count_end", 64'(pkt_count), 64'd0);
    chk("t1_beats", 64'(beats_out - b0), 64'd9);

    // ---------------- T2: 4 x 3-beat with toggling tready ----------------
    b0 = beats_out;
    d0 = drops_seen;
    fork
      begin
        for (int p = 0; p < 4; p++) send_pkt(20 + p, 3, '1, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    wait_drain("t2");
    chk("t2_beats", 64'(beats_out - b0), 64'd12);
    chk("t2_drop_count", 64'(drop_count), 64'd0);
    chk("t2_drop_pulses", 64'(drops_seen - d0), 64'd0);

    // ---------------- T3: oversized 70-beat, then 2-beat ----------------
    b0 = beats_out;
    d0 = drops_seen;
    send_pkt(30, 70, '1, 1'b0, 1'b0);
    send_pkt(31, 2, 64'hFF, 1'b0, 1'b1);
    wait_drain("t3");
    chk("t3_drop_pulses", 64'(drops_seen - d0), 64'd1);
    chk("t3_drop_count", 64'(drop_count), 64'd1);
    chk("t3_beats", 64'(beats_out - b0), 64'd2);
    chk("t3_pkt_count", 64'(pkt_count), 64'd0);

    // ---------------- T4: tuser error, then good packet ----------------
    b0 = beats_out;
    d0 = drops_seen;
    send_pkt(40, 5, 64'h0F, 1'b1, 1'b0);
    send_pkt(41, 4, 64'hF0F0, 1'b0, 1'b1);
    wait_drain("t4");
    chk("t4_drop_pulses", 64'(drops_seen - d0), 64'd1);
    chk("t4_drop_count", 64'(drop_count), 64'd2);
    chk("t4_beats", 64'(beats_out - b0), 64'd4);

    // ---------------- T5: MAX_PKTS+1 one-beat packets ----------------
    b0 = beats_out;
    d0 = drops_seen;
    m_tready = 1'b0;
    for (int p = 0; p < MAXP + 1; p++) begin
      send_pkt(50 + p, 1, 64'(p + 1), 1'b0, (p < MAXP));
    end
    tick(1);
    chk("t5_pkt_count_full", 64'(pkt_count), 64'd16);
    chk("t5_drop_count", 64'(drop_count), 64'd3);
    chk("t5_beats_stalled", 64'(beats_out - b0), 64'd0);
    m_tready = 1'b1;
    wait_drain("t5");
    chk("t5_beats", 64'(beats_out - b0), 64'd16);
    chk("t5_pkt_count_end", 64'(pkt_count), 64'd0);
    chk("t5_drop_pulses", 64'(drops_seen - d0), 64'd1);

    // ---------------- T6: reset mid-output ----------------
    b0 = beats_out;
    send_pkt(60, 40, '1, 1'b0, 1'b1);
    n = 0;
    while ((beats_out - b0) < 5 && n < 100) begin
      tick(1);
      n++;
    end
    chk("t6_output_started", 64'((beats_out - b0) >= 5), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("t6_rst_drop_count", 64'(drop_count), 64'd0);
    chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
    chk("t6_rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("t6_rst_m_tdata", m_tdata[63:0], 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    aresetn = 1'b1;
    tick(1);
    chk("t6_s_tready_back", 64'(s_tready), 64'd1);
    b0 = beats_out;
    send_pkt(70, 2, 64'h7, 1'b0, 1'b1);
    wait_drain("t6");
    chk("t6_beats", 64'(beats_out - b0), 64'd2);
    chk("t6_pkt_count_end", 64'(pkt_count), 64'd0);
    chk("t6_drop_count_end", 64'(drop_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
